sprite_draw_scheduler: RTL and testbench

//  Shares the single VGA adapter write port between NUM_DRAWERS 8x8 sprite drawers (up/down/left/right arrows).

---
 rtl/sprite_draw_scheduler_pkg.sv | 30 +++
 rtl/sprite_draw_scheduler_if.sv | 13 +
 rtl/sprite_draw_scheduler_fifo.sv | 52 +++++
 rtl/sprite_draw_scheduler.sv | 157 +++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared types and constants for the sprite draw scheduler: drawer indices,
// FSM state encoding and the queued request record.
package sprite_draw_scheduler_pkg;

  localparam int SPRITE_PIXELS = 64;
  localparam int SEL_W = 2;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  localparam logic [SEL_W-1:0] DRW_UP    = 2'd0;
  localparam logic [SEL_W-1:0] DRW_DOWN  = 2'd1;
  localparam logic [SEL_W-1:0] DRW_LEFT  = 2'd2;
  localparam logic [SEL_W-1:0] DRW_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_ARM       = 2'd2,
    S_WAIT_DONE = 2'd3
  } sched_state_e;

  // 17-bit queue entry: sel + x + y
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
  } draw_req_t;

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// Draw request handshake between the graphics FSM (master) and the scheduler (slave).
interface sprite_draw_scheduler_if;
  import sprite_draw_scheduler_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [SEL_W-1:0] req_sel;
  logic [X_W-1:0]   req_x;
  logic [Y_W-1:0]   req_y;

  modport master (output req_valid, req_sel, req_x, req_y, input req_ready);
  modport slave  (input req_valid, req_sel, req_x, req_y, output req_ready);
endinterface

// File: rtl/sprite_draw_scheduler_fifo.sv
// Request queue for the scheduler: power-of-2 depth, full/empty flags, push is
// refused whenever full regardless of a same-cycle pop.
module draw_req_fifo
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  draw_req_t wdata,
  input  logic      pop,
  output draw_req_t rdata,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  draw_req_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares the VGA write port among sprite drawers: queues requests, launches one
// drawer at a time and forwards its pixel stream until it reports done or times out.
module sprite_draw_scheduler
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int NUM_DRAWERS = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int TIMEOUT     = 127
) (
  input  logic                         clock,
  input  logic                         reset,
  sprite_draw_scheduler_if.slave       req,
  output logic [NUM_DRAWERS-1:0]       drw_start,
  output logic [X_W-1:0]               drw_refX,
  output logic [Y_W-1:0]               drw_refY,
  input  logic [X_W*NUM_DRAWERS-1:0]   drw_x,
  input  logic [Y_W*NUM_DRAWERS-1:0]   drw_y,
  input  logic [COL_W*NUM_DRAWERS-1:0] drw_colour,
  input  logic [NUM_DRAWERS-1:0]       drw_writeEn,
  input  logic [NUM_DRAWERS-1:0]       drw_done,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COL_W-1:0]             colour,
  output logic                         writeEn,
  output logic                         busy,
  output logic                         timeout_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sched_state_e     state, state_nxt;
  draw_req_t        fifo_in, fifo_head;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [SEL_W-1:0] cur_sel;
  logic [CNT_W-1:0] cnt;
  logic             head_ok, load_cur, set_err, cnt_clr, cnt_inc;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [COL_W-1:0] sel_col;
  logic             sel_we, sel_done, pix_window;

  assign fifo_in.sel   = req.req_sel;
  assign fifo_in.x     = req.req_x;
  assign fifo_in.y     = req.req_y;
  assign req.req_ready = !fifo_full;

  draw_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (req.req_valid),
    .wdata (fifo_in),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Indices past the attached drawers are popped and discarded as errors.
  assign head_ok    = (32'(fifo_head.sel) < NUM_DRAWERS);
  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign pix_window = (state == S_ARM) || (state == S_WAIT_DONE);

  always_comb begin
    drw_start = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_col   = '0;
    sel_we    = 1'b0;
    sel_done  = 1'b0;
    for (int i = 0; i < NUM_DRAWERS; i++) begin
      if (32'(cur_sel) == i) begin
        drw_start[i] = (state == S_LAUNCH);
        sel_x        = drw_x[X_W*i +: X_W];
        sel_y        = drw_y[Y_W*i +: Y_W];
        sel_col      = drw_colour[COL_W*i +: COL_W];
        sel_we       = drw_writeEn[i];
        sel_done     = drw_done[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ARM exists because the freshly started drawer still shows its old done=1.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load_cur  = 1'b0;
    set_err   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load_cur = 1'b1;
          if (head_ok) state_nxt = S_LAUNCH;
          else         set_err   = 1'b1;
        end
      end
      S_LAUNCH: state_nxt = S_ARM;
      S_ARM: begin
        cnt_clr   = 1'b1;
        state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (sel_done) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          set_err   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_sel     <= '0;
      drw_refX    <= '0;
      drw_refY    <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (load_cur) begin
        cur_sel  <= fifo_head.sel;
        drw_refX <= fifo_head.x;
        drw_refY <= fifo_head.y;
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_ONE;
      if (set_err) timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
    end else begin
      x       <= sel_x;
      y       <= sel_y;
      colour  <= sel_col;
      writeEn <= sel_we && pix_window;
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench: stub drawers feed the scheduler, a monitor logs start
// pulses and VGA writes, each test compares them against a request-level model.
`timescale 1ns/1ps
module tb_sprite_draw_scheduler;
  import sprite_draw_scheduler_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sprite_draw_scheduler_if rif ();

  logic [N-1:0]   drw_start, drw_writeEn, drw_done;
  logic [7:0]     drw_refX, x;
  logic [6:0]     drw_refY, y;
  logic [8*N-1:0] drw_x;
  logic [7*N-1:0] drw_y;
  logic [3*N-1:0] drw_colour;
  logic [2:0]     colour;
  logic           writeEn, busy, timeout_err;

  sprite_draw_scheduler #(.NUM_DRAWERS(N), .QUEUE_DEPTH(4), .TIMEOUT(127)) dut (
    .clock(clock), .reset(reset), .req(rif),
    .drw_start(drw_start), .drw_refX(drw_refX), .drw_refY(drw_refY),
    .drw_x(drw_x), .drw_y(drw_y), .drw_colour(drw_colour),
    .drw_writeEn(drw_writeEn), .drw_done(drw_done),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Stub drawers: mode 0 normal, 1 done stuck high, 2 done stuck low.
  int         mode [N];
  logic       act  [N];
  int         k    [N];
  logic [7:0] rx   [N];
  logic [6:0] ry   [N];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        act[i] <= 1'b0; k[i] <= 0; rx[i] <= '0; ry[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (drw_start[i] && mode[i] == 0) begin
          act[i] <= 1'b1; k[i] <= 0; rx[i] <= drw_refX; ry[i] <= drw_refY;
        end else if (act[i]) begin
          if (k[i] == SPRITE_PIXELS) act[i] <= 1'b0;
          else                       k[i] <= k[i] + 1;
        end
      end
    end
  end

  always_comb begin
    drw_x = '0; drw_y = '0; drw_colour = '0; drw_writeEn = '0; drw_done = '0;
    for (int i = 0; i < N; i++) begin
      drw_writeEn[i]      = act[i] && k[i] >= 1;
      drw_x[8*i +: 8]     = rx[i] + 8'(((k[i] > 0) ? k[i] - 1 : 0) % 8);
      drw_y[7*i +: 7]     = ry[i] - 7'(((k[i] > 0) ? k[i] - 1 : 0) / 8);
      drw_colour[3*i +: 3] = 3'(i + 1);
      drw_done[i]         = (mode[i] == 2) ? 1'b0 :
                            (mode[i] == 1) ? 1'b1 : !(act[i] && k[i] >= 1);
    end
  end

  pix_t pix_q [$];
  int   start_q [$];
  int   start_t [$];
  int   cyc = 0;
  int   checks = 0, passes = 0;
  draw_req_t exp_q [$];

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (writeEn) pix_q.push_back({x, y, colour});
      if (drw_start != '0) begin
        start_q.push_back(int'(drw_start));
        start_t.push_back(cyc);
      end
    end
  end

  // Reference: drawer p-th pixel walks rows of 8 upward from (refX, refY).
  function automatic pix_t model_pix(draw_req_t r, int p);
    pix_t q;
    q.x = r.x + 8'(p % 8);
    q.y = r.y - 7'(p / 8);
    q.c = 3'(r.sel + 1);
    return q;
  endfunction

  function automatic int stream_bad();
    int bad = 0;
    for (int i = 0; i < pix_q.size() && i / SPRITE_PIXELS < exp_q.size(); i++)
      if (pix_q[i] !== model_pix(exp_q[i / SPRITE_PIXELS], i % SPRITE_PIXELS)) bad++;
    return bad;
  endfunction

  function automatic int starts_bad();
    int bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= start_q.size() || start_q[i] != (1 << exp_q[i].sel)) bad++;
    return bad;
  endfunction

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic clear_logs();
    pix_q.delete(); start_q.delete(); start_t.delete(); exp_q.delete();
  endtask

  task automatic push(input draw_req_t r, output bit ok, output logic [N-1:0] st_acc);
    bit rdy;
    ok = 1'b0;
    st_acc = '0;
    rif.req_valid = 1'b1; rif.req_sel = r.sel; rif.req_x = r.x; rif.req_y = r.y;
    for (int n = 0; n < 400; n++) begin
      rdy = rif.req_ready;
      st_acc = drw_start;
      tick();
      if (rdy) begin ok = 1'b1; break; end
    end
    rif.req_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
    tick();
  endtask

  function automatic draw_req_t rnd_req(input logic [1:0] s);
    draw_req_t r;
    r.sel = s;
    r.x   = 8'($urandom_range(0, 255));
    r.y   = 7'($urandom_range(0, 127));
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #7;
    checks++;
    if ({drw_start, drw_refX, drw_refY, x, y, colour, writeEn, busy, timeout_err} !== '0)
      $display("FAIL reset_outputs got %0h want 0",
               {drw_start, drw_refX, drw_refY, x, y, colour, writeEn, busy, timeout_err});
    else passes++;
    @(negedge clock); reset = 1'b0; #1;
    checks++;
    if ({rif.req_ready, busy} !== 2'b10)
      $display("FAIL reset_release ready/busy got %b want 10", {rif.req_ready, busy});
    else passes++;
  endtask

  task automatic test_single();
    bit ok, ok2; logic [N-1:0] st; draw_req_t r;
    clear_logs();
    r.sel = DRW_UP; r.x = 8'd40; r.y = 7'd60;
    exp_q.push_back(r);
    push(r, ok, st);
    wait_idle(ok2);
    checks++;
    if (!(ok && ok2)) $display("FAIL single_handshake got %b%b want 11", ok, ok2); else passes++;
    checks++;
    if (start_q.size() != 1 || start_q[0] != 1)
      $display("FAIL single_start got %0d pulses (first %0h) want 1 pulse of 1",
               start_q.size(), start_q.size() ? start_q[0] : 0);
    else passes++;
    checks++;
    if (pix_q.size() != SPRITE_PIXELS)
      $display("FAIL single_count got %0d want %0d", pix_q.size(), SPRITE_PIXELS);
    else passes++;
    checks++;
    if (stream_bad() != 0) $display("FAIL single_pixels got %0d bad want 0", stream_bad());
    else passes++;
    checks++;
    if ({busy, timeout_err} !== 2'b00)
      $display("FAIL single_idle busy/err got %b want 00", {busy, timeout_err});
    else passes++;
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok = 1'b1; logic [N-1:0] st; draw_req_t r;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      r = rnd_req((i < 4) ? 2'(i) : 2'($urandom_range(0, 3)));
      exp_q.push_back(r);
      push(r, ok, st);
      all_ok &= ok;
    end
    checks++;
    if (rif.req_ready !== 1'b0) $display("FAIL b2b_full_ready got %b want 0", rif.req_ready);
    else passes++;
    wait_idle(ok);
    checks++;
    if (!(all_ok && ok)) $display("FAIL b2b_handshake got %b%b want 11", all_ok, ok); else passes++;
    checks++;
    if (starts_bad() != 0 || start_q.size() != 5)
      $display("FAIL b2b_starts got %0d bad of %0d want 0 of 5", starts_bad(), start_q.size());
    else passes++;
    checks++;
    if (pix_q.size() != 5 * SPRITE_PIXELS || stream_bad() != 0)
      $display("FAIL b2b_pixels got %0d px %0d bad want %0d px 0 bad",
               pix_q.size(), stream_bad(), 5 * SPRITE_PIXELS);
    else passes++;
  endtask

  task automatic test_full_pop_same_cycle();
    bit ok, all_ok = 1'b1; logic [N-1:0] st; draw_req_t r;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      r = rnd_req(2'($urandom_range(0, 3)));
      exp_q.push_back(r);
      push(r, ok, st);
      all_ok &= ok;
    end
    checks++;
    if (rif.req_ready !== 1'b0) $display("FAIL full_ready got %b want 0", rif.req_ready);
    else passes++;
    r = rnd_req(2'($urandom_range(0, 3)));
    exp_q.push_back(r);
    push(r, ok, st);
    all_ok &= ok;
    checks++;
    if (st !== N'(1 << exp_q[1].sel))
      $display("FAIL full_accept_cycle start got %b want %b", st, N'(1 << exp_q[1].sel));
    else passes++;
    wait_idle(ok);
    checks++;
    if (!(all_ok && ok) || pix_q.size() != 6 * SPRITE_PIXELS || stream_bad() != 0)
      $display("FAIL full_stream got ok=%b %0d px %0d bad want ok=1 %0d px 0 bad",
               all_ok && ok, pix_q.size(), stream_bad(), 6 * SPRITE_PIXELS);
    else passes++;
  endtask

  task automatic test_done_stuck_high();
    bit ok; logic [N-1:0] st; draw_req_t r; int t1, n;
    clear_logs();
    mode[2] = 1;
    r = rnd_req(DRW_LEFT);
    push(r, ok, st);
    for (n = 0; n < 50 && start_q.size() == 0; n++) tick();
    for (n = 0; n < 50 && busy; n++) tick();
    t1 = cyc;
    checks++;
    if (start_q.size() != 1 || (t1 - start_t[0]) != 3)
      $display("FAIL stuck_high_exit got %0d starts, %0d cycles want 1 start, 3 cycles",
               start_q.size(), start_q.size() ? t1 - start_t[0] : -1);
    else passes++;
    checks++;
    if ({timeout_err, pix_q.size() == 0} !== 2'b01)
      $display("FAIL stuck_high_err got err=%b px=%0d want err=0 px=0", timeout_err, pix_q.size());
    else passes++;
    mode[2] = 0;
  endtask

  task automatic test_timeout();
    bit ok1, ok2, ok3; logic [N-1:0] st; draw_req_t r0, r1;
    clear_logs();
    mode[1] = 2;
    r0 = rnd_req(DRW_DOWN);
    r1 = rnd_req(DRW_RIGHT);
    exp_q.push_back(r1);
    push(r0, ok1, st);
    push(r1, ok2, st);
    wait_idle(ok3);
    checks++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_err got %b want 1", timeout_err);
    else passes++;
    checks++;
    if (start_q.size() != 2 || start_q[0] != 2 || start_q[1] != 8)
      $display("FAIL timeout_starts got %0d pulses want 2 (2 then 8)", start_q.size());
    else passes++;
    checks++;
    if (start_q.size() != 2 || start_t[1] - start_t[0] != 130)
      $display("FAIL timeout_span got %0d want 130",
               start_q.size() == 2 ? start_t[1] - start_t[0] : -1);
    else passes++;
    checks++;
    if (!(ok1 && ok2 && ok3) || pix_q.size() != SPRITE_PIXELS || stream_bad() != 0)
      $display("FAIL timeout_next got %0d px %0d bad want %0d px 0 bad",
               pix_q.size(), stream_bad(), SPRITE_PIXELS);
    else passes++;
    mode[1] = 0;
  endtask

  task automatic test_reset_mid_draw();
    bit ok, ok2; logic [N-1:0] st; draw_req_t r;
    clear_logs();
    push(rnd_req(DRW_UP), ok, st);
    push(rnd_req(DRW_LEFT), ok, st);
    for (int n = 0; n < 500 && pix_q.size() < 30; n++) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({drw_start, drw_refX, drw_refY, x, y, colour, writeEn, busy, timeout_err} !== '0)
      $display("FAIL midreset_outputs got %0h want 0",
               {drw_start, drw_refX, drw_refY, x, y, colour, writeEn, busy, timeout_err});
    else passes++;
    checks++;
    if (rif.req_ready !== 1'b1) $display("FAIL midreset_ready got %b want 1", rif.req_ready);
    else passes++;
    clear_logs();
    @(negedge clock); reset = 1'b0; #1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || start_q.size() != 0)
      $display("FAIL midreset_fifo_empty got busy=%b starts=%0d want 0 0", busy, start_q.size());
    else passes++;
    r = rnd_req(DRW_DOWN);
    exp_q.push_back(r);
    push(r, ok, st);
    wait_idle(ok2);
    checks++;
    if (!(ok && ok2) || starts_bad() != 0 || start_q.size() != 1)
      $display("FAIL midreset_restart_start got %0d pulses want 1", start_q.size());
    else passes++;
    checks++;
    if (pix_q.size() != SPRITE_PIXELS || stream_bad() != 0)
      $display("FAIL midreset_restart_pixels got %0d px %0d bad want %0d px 0 bad",
               pix_q.size(), stream_bad(), SPRITE_PIXELS);
    else passes++;
  endtask

  initial begin
    rif.req_valid = 1'b0; rif.req_sel = '0; rif.req_x = '0; rif.req_y = '0;
    for (int i = 0; i < N; i++) mode[i] = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop_same_cycle();
    test_done_stuck_high();
    test_timeout();
    test_reset_mid_draw();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
